// File: rtl/ws2812_decoder.sv
// WS2812-style single-wire receiver: classifies high pulses as 0/1 and assembles 24-bit {r,g,b} pixels.
// pixel_valid 3 clk after the line falls on the 24th bit; no backpressure, every event is a 1-cycle pulse.
module ws2812_decoder #(
   parameter int T_MIN_HIGH   = 8,
   parameter int T_BIT_THRESH = 30,
   parameter int T_MAX_HIGH   = 60,
   parameter int T_RESET      = 400,
   parameter int CNT_W        = 10,
   parameter int IDX_W        = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   output logic [7:0]       r,
   output logic [7:0]       g,
   output logic [7:0]       b,
   output logic             pixel_valid,
   output logic [IDX_W-1:0] pixel_idx,
   output logic             frame_done,
   output logic             err_glitch,
   output logic             err_long,
   output logic             err_partial,
   output logic             busy
);

   localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(T_MIN_HIGH);
   localparam logic [CNT_W-1:0] THR_C    = CNT_W'(T_BIT_THRESH);
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(T_MAX_HIGH);
   localparam logic [CNT_W-1:0] RST_M1_C = CNT_W'(T_RESET - 1);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

   typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             din_m;
   logic             din_s;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] low_cnt;
   logic [4:0]       bit_cnt;
   logic [22:0]      shift_q;
   logic             ev_long;
   logic             ev_glitch;
   logic             ev_bit;
   logic             ev_gap;
   logic             sync_done;
   logic             bit_val;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + ONE_C;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         din_m <= 1'b0;
         din_s <= 1'b0;
      end else begin
         din_m <= din;
         din_s <= din_m;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_SYNC;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_SYNC: if (sync_done) state_nxt = S_IDLE;
         S_IDLE: if (din_s) state_nxt = S_HIGH;
         S_HIGH: begin
            if (ev_long || ev_glitch) state_nxt = S_SYNC;
            else if (ev_bit)          state_nxt = S_LOW;
         end
         S_LOW: begin
            if (din_s)       state_nxt = S_HIGH;
            else if (ev_gap) state_nxt = S_IDLE;
         end
         default: state_nxt = S_SYNC;
      endcase
   end

   always_comb begin
      busy      = (state == S_HIGH) || (state == S_LOW);
      ev_long   = (state == S_HIGH) && din_s && (high_cnt >= MAX_C);
      ev_glitch = (state == S_HIGH) && !din_s && (high_cnt < MIN_C);
      ev_bit    = (state == S_HIGH) && !din_s && (high_cnt >= MIN_C);
      ev_gap    = (state == S_LOW) && !din_s && (low_cnt >= RST_M1_C);
      sync_done = (state == S_SYNC) && !din_s && (low_cnt >= RST_M1_C);
      bit_val   = (high_cnt >= THR_C);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r           <= '0;
         g           <= '0;
         b           <= '0;
         pixel_valid <= 1'b0;
         pixel_idx   <= '0;
         frame_done  <= 1'b0;
         err_glitch  <= 1'b0;
         err_long    <= 1'b0;
         err_partial <= 1'b0;
         high_cnt    <= '0;
         low_cnt     <= '0;
         bit_cnt     <= '0;
         shift_q     <= '0;
      end else begin
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         err_glitch  <= 1'b0;
         err_long    <= 1'b0;
         err_partial <= 1'b0;
         if (pixel_valid) pixel_idx <= pixel_idx + 1'b1;
         case (state)
            S_SYNC: low_cnt <= din_s ? '0 : sat_inc(low_cnt);
            S_IDLE: if (din_s) high_cnt <= ONE_C;
            S_HIGH: begin
               if (ev_long) begin
                  err_long  <= 1'b1;
                  bit_cnt   <= '0;
                  pixel_idx <= '0;
                  low_cnt   <= '0;
               end else if (din_s) begin
                  high_cnt <= sat_inc(high_cnt);
               end else if (ev_glitch) begin
                  // the low sample that ends the glitch already counts toward resync
                  err_glitch <= 1'b1;
                  bit_cnt    <= '0;
                  pixel_idx  <= '0;
                  low_cnt    <= ONE_C;
               end else begin
                  shift_q <= {shift_q[21:0], bit_val};
                  low_cnt <= ONE_C;
                  if (bit_cnt == 5'd23) begin
                     {r, g, b}   <= {shift_q, bit_val};
                     pixel_valid <= 1'b1;
                     bit_cnt     <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
            end
            S_LOW: begin
               if (din_s) begin
                  high_cnt <= ONE_C;
               end else if (ev_gap) begin
                  frame_done  <= 1'b1;
                  err_partial <= (bit_cnt != 5'd0);
                  bit_cnt     <= '0;
                  pixel_idx   <= '0;
                  low_cnt     <= '0;
               end else begin
                  low_cnt <= sat_inc(low_cnt);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_decoder.sv
// Directed bench for ws2812_decoder: framing, bit thresholds, error paths and mid-frame reset.
module tb_ws2812_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       din;
   logic [7:0] r, g, b;
   logic       pixel_valid;
   logic [9:0] pixel_idx;
   logic       frame_done, err_glitch, err_long, err_partial, busy;

   always #5 clk = ~clk;

   ws2812_decoder dut (
      .clk(clk), .rst(rst), .din(din),
      .r(r), .g(g), .b(b),
      .pixel_valid(pixel_valid), .pixel_idx(pixel_idx),
      .frame_done(frame_done), .err_glitch(err_glitch), .err_long(err_long),
      .err_partial(err_partial), .busy(busy)
   );

   int          cyc = 0;
   int          n_pix = 0, n_frame = 0, n_glitch = 0, n_long = 0, n_partial = 0, n_pf = 0;
   int          long_cyc = 0;
   logic [23:0] pix_rgb [64];
   logic [9:0]  pix_idx [64];
   int          pix_cyc [64];

   // event recorder, sampled 1 time unit after each active edge
   always @(posedge clk) begin
      #1;
      cyc <= cyc + 1;
      if (pixel_valid) begin
         if (n_pix < 64) begin
            pix_rgb[n_pix] <= {r, g, b};
            pix_idx[n_pix] <= pixel_idx;
            pix_cyc[n_pix] <= cyc + 1;
         end
         n_pix <= n_pix + 1;
      end
      if (frame_done)  n_frame <= n_frame + 1;
      if (err_glitch)  n_glitch <= n_glitch + 1;
      if (err_long) begin
         n_long   <= n_long + 1;
         long_cyc <= cyc + 1;
      end
      if (err_partial) n_partial <= n_partial + 1;
      if (err_partial && frame_done) n_pf <= n_pf + 1;
   end

   int checks = 0, errors = 0;
   int p0, f0, g0, l0, pt0, pf0;
   int last_fall = 0, last_rise = 0, fall, rise;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pix(input string tag, input int k, input logic [23:0] rgb, input logic [9:0] idx);
      if (k < 64) begin
         chk({tag, "_rgb"}, {8'h0, pix_rgb[k]}, {8'h0, rgb});
         chk({tag, "_idx"}, {22'h0, pix_idx[k]}, {22'h0, idx});
      end else begin
         chk({tag, "_logslot"}, k, 0);
      end
   endtask

   task automatic snap();
      p0 = n_pix; f0 = n_frame; g0 = n_glitch; l0 = n_long; pt0 = n_partial; pf0 = n_pf;
   endtask

   task automatic hold(input logic v, input int n);
      if (v && !din) last_rise = cyc;
      if (!v && din) last_fall = cyc;
      din = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_pulse(input int hi, input int lo);
      hold(1'b1, hi);
      hold(1'b0, lo);
   endtask

   task automatic send_bits(input logic [23:0] d, input int first, input int last);
      for (int i = first; i >= last; i--)
         if (d[i]) send_pulse(40, 20);
         else      send_pulse(20, 40);
   endtask

   task automatic send_pixel(input logic [23:0] d);
      send_bits(d, 23, 0);
   endtask

   task automatic gap();
      hold(1'b0, 450);
   endtask

   initial begin
      rst = 1'b1;
      din = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rgb", {8'h0, r, g, b}, 32'h0);
      chk("rst_idx", {22'h0, pixel_idx}, 32'h0);
      chk("rst_pulses", {27'h0, pixel_valid, frame_done, err_glitch, err_long, err_partial}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      rst = 1'b0;
      hold(1'b0, 420);
      chk("sync_busy", {31'h0, busy}, 32'h0);

      // single pixel A5/3C/0F
      snap();
      send_pixel(24'hA53C0F);
      fall = last_fall;
      chk("t1_busy_in_frame", {31'h0, busy}, 32'h1);
      gap();
      chk("t1_npix", n_pix - p0, 1);
      chk_pix("t1_pix", p0, 24'hA53C0F, 10'd0);
      chk("t1_latency", pix_cyc[p0] - fall, 3);
      chk("t1_frames", n_frame - f0, 1);
      chk("t1_errs", (n_glitch - g0) + (n_long - l0) + (n_partial - pt0), 0);
      chk("t1_idx_after", {22'h0, pixel_idx}, 32'h0);
      chk("t1_busy_after", {31'h0, busy}, 32'h0);

      // back-to-back pixels
      snap();
      send_pixel(24'h010203);
      send_pixel(24'h040506);
      send_pixel(24'hFF0080);
      gap();
      chk("t2_npix", n_pix - p0, 3);
      chk_pix("t2_p0", p0, 24'h010203, 10'd0);
      chk_pix("t2_p1", p0 + 1, 24'h040506, 10'd1);
      chk_pix("t2_p2", p0 + 2, 24'hFF0080, 10'd2);
      chk("t2_frames", n_frame - f0, 1);
      snap();
      send_pixel(24'h123456);
      gap();
      chk("t2_next_npix", n_pix - p0, 1);
      chk_pix("t2_next", p0, 24'h123456, 10'd0);

      // thresholds: 29->0, 30->1, 60->1, 8->0, then twenty short bits
      snap();
      send_pulse(29, 31);
      send_pulse(30, 30);
      send_pulse(60, 30);
      send_pulse(8, 30);
      for (int i = 0; i < 20; i++) send_pulse(20, 40);
      gap();
      chk("t3_npix", n_pix - p0, 1);
      chk_pix("t3_pix", p0, 24'h600000, 10'd0);
      chk("t3_errs", (n_glitch - g0) + (n_long - l0) + (n_partial - pt0), 0);
      snap();
      send_pulse(7, 50);
      hold(1'b0, 450);
      chk("t3_glitch", n_glitch - g0, 1);
      chk("t3_glitch_npix", n_pix - p0, 0);
      chk("t3_glitch_frames", n_frame - f0, 0);
      chk("t3_glitch_long", n_long - l0, 0);

      // over-long high mid-pixel, then a pixel during resync is ignored
      snap();
      send_bits(24'hA80000, 23, 19);
      hold(1'b1, 70);
      rise = last_rise;
      hold(1'b0, 100);
      send_pixel(24'hFFFFFF);
      gap();
      chk("t4_long", n_long - l0, 1);
      chk("t4_long_cycle", long_cyc - rise, 63);
      chk("t4_npix", n_pix - p0, 0);
      chk("t4_frames", n_frame - f0, 0);
      chk("t4_glitch", n_glitch - g0, 0);
      snap();
      send_pixel(24'h0A0B0C);
      gap();
      chk("t4_recover_npix", n_pix - p0, 1);
      chk_pix("t4_recover", p0, 24'h0A0B0C, 10'd0);
      chk("t4_recover_frames", n_frame - f0, 1);

      // partial pixel
      snap();
      send_bits(24'h5A5A5A, 23, 14);
      gap();
      chk("t5_partial", n_partial - pt0, 1);
      chk("t5_frames", n_frame - f0, 1);
      chk("t5_same_cycle", n_pf - pf0, 1);
      chk("t5_npix", n_pix - p0, 0);

      // reset mid-pixel
      snap();
      send_bits(24'hC3C3C3, 23, 12);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_rgb", {8'h0, r, g, b}, 32'h0);
      chk("t6_rst_idx", {22'h0, pixel_idx}, 32'h0);
      chk("t6_rst_busy", {31'h0, busy}, 32'h0);
      rst = 1'b0;
      send_bits(24'hC3C3C3, 11, 0);
      hold(1'b0, 450);
      chk("t6_no_decode", n_pix - p0, 0);
      send_pixel(24'h5A6B7C);
      gap();
      chk("t6_npix", n_pix - p0, 1);
      chk_pix("t6_pix", p0, 24'h5A6B7C, 10'd0);
      chk("t6_frames", n_frame - f0, 1);
      chk("t6_errs", (n_glitch - g0) + (n_long - l0) + (n_partial - pt0), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
